// File: rtl/unidade_controle_multiciclo.sv
// unidade_controle_multiciclo -- control unit for a multicycle load/store datapath.
// Sequences fetch, decode and execute phases for load, store, R-type, I-type and
// conditional branch instructions. It drives the datapath enables and selects, and it
// counts retired instructions.
//
// Build option ILLEGAL_TRAP_EN:
//   defined   -> an unknown opcode parks the FSM in TRAP and raises the sticky
//                illegal flag. Only reset leaves TRAP.
//   undefined -> an unknown opcode retires as a NOP straight from DECODE.
//                illegal is tied low and TRAP is never entered.
//
// state     | code | meaning
// ----------+------+--------------------------------------------------------------
// FETCH     |  0   | read instruction at PC; IR and PC+4 load when mem_ready
// DECODE    |  1   | dispatch on opcode; ALU precomputes the branch target
// MEM_ADDR  |  2   | ALU forms rs1 + imm effective address
// MEM_READ  |  3   | data read at ALUOut, held until mem_ready
// MEM_WB    |  4   | load data written to the register file
// MEM_WRITE |  5   | data write at ALUOut, held until mem_ready
// EXEC_R    |  6   | register-register ALU operation (funct decoded)
// EXEC_I    |  7   | register-immediate ALU operation
// ALU_WB    |  8   | ALU result written to the register file
// BRANCH    |  9   | compare rs1/rs2; PC takes ALUOut when zero
// TRAP      | 10   | illegal opcode seen; all strobes idle until reset
// 11..15    |  --  | not used; return to FETCH on the next edge

module unidade_controle_multiciclo (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IorD,
    output logic        MemToReg,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic        PCSource,
    output logic [3:0]  state,
    output logic [15:0] retired,
    output logic        illegal
);

    typedef enum logic [3:0] {
        s_fetch     = 4'd0,
        s_decode    = 4'd1,
        s_mem_addr  = 4'd2,
        s_mem_read  = 4'd3,
        s_mem_wb    = 4'd4,
        s_mem_write = 4'd5,
        s_exec_r    = 4'd6,
        s_exec_i    = 4'd7,
        s_alu_wb    = 4'd8,
        s_branch    = 4'd9,
        s_trap      = 4'd10
    } state_t;

    localparam logic [6:0] op_load   = 7'b0000011;
    localparam logic [6:0] op_store  = 7'b0100011;
    localparam logic [6:0] op_rtype  = 7'b0110011;
    localparam logic [6:0] op_itype  = 7'b0010011;
    localparam logic [6:0] op_branch = 7'b1100011;

    localparam logic [1:0] srcb_rs2  = 2'b00;
    localparam logic [1:0] srcb_four = 2'b01;
    localparam logic [1:0] srcb_imm  = 2'b10;
    localparam logic [1:0] srcb_boff = 2'b11;

    localparam logic [1:0] aluop_add   = 2'b00;
    localparam logic [1:0] aluop_sub   = 2'b01;
    localparam logic [1:0] aluop_funct = 2'b10;
    localparam logic [1:0] aluop_and   = 2'b11;

    state_t state_q;
    state_t state_d;
    logic   retire;

    // The strobes are computed ungated first. Reset masks them further down,
    // so no stray enable reaches the datapath while rst_n is held low.
    logic pc_write_raw;
    logic ir_write_raw;
    logic reg_write_raw;
    logic mem_read_raw;
    logic mem_write_raw;

`ifdef ILLEGAL_TRAP_EN
    logic enter_trap;
    logic illegal_q;
`endif

    // State register and retirement counter; reset wins even in the middle of a memory wait.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= s_fetch;
            retired <= 16'd0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                retired <= retired + 16'd1;
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    // Sticky illegal flag: set on entry to TRAP and cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (enter_trap) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // Next-state selection, plus the completion pulse for each instruction.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        enter_trap = 1'b0;
`endif
        case (state_q)
            s_fetch: begin
                if (mem_ready) begin
                    state_d = s_decode;
                end
            end
            s_decode: begin
                case (opcode)
                    op_load, op_store: state_d = s_mem_addr;
                    op_rtype:          state_d = s_exec_r;
                    op_itype:          state_d = s_exec_i;
                    op_branch:         state_d = s_branch;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d    = s_trap;
                        enter_trap = 1'b1;
`else
                        state_d = s_fetch;
                        retire  = 1'b1;
`endif
                    end
                endcase
            end
            s_mem_addr: begin
                // The opcode was already checked in DECODE, so only load vs store remains.
                state_d = (opcode == op_store) ? s_mem_write : s_mem_read;
            end
            s_mem_read: begin
                if (mem_ready) begin
                    state_d = s_mem_wb;
                end
            end
            s_mem_wb: begin
                state_d = s_fetch;
                retire  = 1'b1;
            end
            s_mem_write: begin
                if (mem_ready) begin
                    state_d = s_fetch;
                    retire  = 1'b1;
                end
            end
            s_exec_r, s_exec_i: begin
                state_d = s_alu_wb;
            end
            s_alu_wb: begin
                state_d = s_fetch;
                retire  = 1'b1;
            end
            s_branch: begin
                state_d = s_fetch;
                retire  = 1'b1;
            end
            s_trap: begin
`ifdef ILLEGAL_TRAP_EN
                state_d = s_trap;
`else
                state_d = s_fetch;
`endif
            end
            default: begin
                state_d = s_fetch;
            end
        endcase
    end

    // Moore decode of the datapath controls. Only the fetch and branch enables look at an input.
    always_comb begin
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        IorD          = 1'b0;
        MemToReg      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = srcb_rs2;
        ALUOp         = aluop_add;
        PCSource      = 1'b0;
        case (state_q)
            s_fetch: begin
                mem_read_raw = 1'b1;
                ALUSrcB      = srcb_four;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
            end
            s_decode: begin
                ALUSrcB = srcb_boff;
            end
            s_mem_addr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = srcb_imm;
            end
            s_mem_read: begin
                mem_read_raw = 1'b1;
                IorD         = 1'b1;
            end
            s_mem_wb: begin
                reg_write_raw = 1'b1;
                MemToReg      = 1'b1;
            end
            s_mem_write: begin
                mem_write_raw = 1'b1;
                IorD          = 1'b1;
            end
            s_exec_r: begin
                ALUSrcA = 1'b1;
                ALUSrcB = srcb_rs2;
                ALUOp   = aluop_funct;
            end
            s_exec_i: begin
                ALUSrcA = 1'b1;
                ALUSrcB = srcb_imm;
                ALUOp   = aluop_and;
            end
            s_alu_wb: begin
                reg_write_raw = 1'b1;
            end
            s_branch: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = srcb_rs2;
                ALUOp        = aluop_sub;
                PCSource     = 1'b1;
                pc_write_raw = zero;
            end
            default: begin
            end
        endcase
    end

    assign PCWrite  = rst_n & pc_write_raw;
    assign IRWrite  = rst_n & ir_write_raw;
    assign RegWrite = rst_n & reg_write_raw;
    assign MemRead  = rst_n & mem_read_raw;
    assign MemWrite = rst_n & mem_write_raw;

    assign state = state_q;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Testbench for unidade_controle_multiciclo.
// Randomized instruction stream with a scoreboard. The driver builds each
// instruction's expected cycle trace from a phase-level model and queues it. The
// monitor collects the DUT trace between returns to FETCH and compares the two.
// Directed sections cover reset, a reset during a store wait, illegal opcodes and
// the retired-counter wrap.

module tb_unidade_controle_multiciclo;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        PCWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        IorD;
    logic        MemToReg;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ALUOp;
    logic        PCSource;
    logic [3:0]  state;
    logic [15:0] retired;
    logic        illegal;

    unidade_controle_multiciclo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .PCWrite   (PCWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IorD      (IorD),
        .MemToReg  (MemToReg),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .PCSource  (PCSource),
        .state     (state),
        .retired   (retired),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int K_LOAD   = 0;
    localparam int K_STORE  = 1;
    localparam int K_RTYPE  = 2;
    localparam int K_ITYPE  = 3;
    localparam int K_BRANCH = 4;
    localparam int K_NOP    = 5;

    int          n_checks = 0;
    int          n_fail   = 0;
    string       sb_trace[$];
    logic [15:0] sb_ret[$];
    int          sb_kind[$];
    logic [15:0] model_ret;
    bit          mon_pause;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
        end
    endtask

    function automatic bit rbit();
        return 1'($urandom);
    endfunction

    // Datapath selects that each state presents, packed as
    // {ALUSrcA, ALUSrcB, ALUOp, PCSource, IorD, MemToReg}.
    function automatic logic [7:0] moore_of(input int st);
        case (st)
            0:       return {1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
            1:       return {1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0};
            2:       return {1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
            3:       return {1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
            4:       return {1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};
            5:       return {1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
            6:       return {1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0};
            7:       return {1'b1, 2'b10, 2'b11, 1'b0, 1'b0, 1'b0};
            9:       return {1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0};
            default: return 8'h00;
        endcase
    endfunction

    // Strobes {PCWrite, IRWrite, RegWrite, MemRead, MemWrite} for one cycle of a phase.
    function automatic logic [4:0] strobes_of(input int st, input bit mr, input bit zr);
        case (st)
            0:       return {mr, mr, 1'b0, 1'b1, 1'b0};
            3:       return 5'b00010;
            4:       return 5'b00100;
            5:       return 5'b00001;
            8:       return 5'b00100;
            9:       return {zr, 4'b0000};
            default: return 5'b00000;
        endcase
    endfunction

    function automatic logic [6:0] pick_illegal();
        logic [6:0] op;
        do begin
            op = 7'($urandom);
        end while (op inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH});
        return op;
    endfunction

    // Build the phase timeline for one instruction, optionally queue its expected trace,
    // then drive it cycle by cycle (entered and left on a falling edge).
    task automatic run_instr(input int kind, input int wf, input int wm, input bit zb, input bit score);
        int    sts[$];
        bit    mrs[$];
        bit    zrs[$];
        string tr;
        for (int k = 0; k <= wf; k++) begin
            sts.push_back(0);
            mrs.push_back(k == wf);
        end
        sts.push_back(1);
        mrs.push_back(rbit());
        case (kind)
            K_LOAD: begin
                sts.push_back(2); mrs.push_back(rbit());
                for (int k = 0; k <= wm; k++) begin
                    sts.push_back(3); mrs.push_back(k == wm);
                end
                sts.push_back(4); mrs.push_back(rbit());
            end
            K_STORE: begin
                sts.push_back(2); mrs.push_back(rbit());
                for (int k = 0; k <= wm; k++) begin
                    sts.push_back(5); mrs.push_back(k == wm);
                end
            end
            K_RTYPE: begin
                sts.push_back(6); mrs.push_back(rbit());
                sts.push_back(8); mrs.push_back(rbit());
            end
            K_ITYPE: begin
                sts.push_back(7); mrs.push_back(rbit());
                sts.push_back(8); mrs.push_back(rbit());
            end
            K_BRANCH: begin
                sts.push_back(9); mrs.push_back(rbit());
            end
            default: begin
            end
        endcase
        for (int i = 0; i < sts.size(); i++) begin
            zrs.push_back((sts[i] == 9) ? zb : rbit());
        end
        tr = "";
        for (int i = 0; i < sts.size(); i++) begin
            tr = {tr, $sformatf("%0d:%02h:%02h;", sts[i], moore_of(sts[i]), strobes_of(sts[i], mrs[i], zrs[i]))};
        end
        model_ret = model_ret + 16'd1;
        if (score) begin
            sb_trace.push_back(tr);
            sb_ret.push_back(model_ret);
            sb_kind.push_back(kind);
        end
        case (kind)
            K_LOAD:   opcode = OP_LOAD;
            K_STORE:  opcode = OP_STORE;
            K_RTYPE:  opcode = OP_RTYPE;
            K_ITYPE:  opcode = OP_ITYPE;
            K_BRANCH: opcode = OP_BRANCH;
            default:  opcode = pick_illegal();
        endcase
        for (int i = 0; i < sts.size(); i++) begin
            mem_ready = mrs[i];
            zero      = zrs[i];
            @(negedge clk);
        end
    endtask

    task automatic step(input bit mr, input bit zr);
        mem_ready = mr;
        zero      = zr;
        @(negedge clk);
    endtask

    // Monitor: accumulate the DUT trace and score it each time the FSM returns to FETCH.
    initial begin : monitor
        string       cur;
        string       exp_tr;
        logic [15:0] exp_r;
        int          prev;
        int          k;
        cur  = "";
        prev = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n || mon_pause) begin
                cur  = "";
                prev = 0;
            end else begin
                if (state == 4'd0 && prev != 0) begin
                    if (sb_trace.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_completion: got trace \"%s\", expected none", cur);
                    end else begin
                        exp_tr = sb_trace.pop_front();
                        exp_r  = sb_ret.pop_front();
                        k      = sb_kind.pop_front();
                        check_str($sformatf("trace_kind%0d", k), cur, exp_tr);
                        check($sformatf("retired_kind%0d", k), 32'(retired), 32'(exp_r));
                    end
                    cur = "";
                end
                if (cur.len() < 120) begin
                    cur = {cur, $sformatf("%0d:%02h:%02h;", state,
                           {ALUSrcA, ALUSrcB, ALUOp, PCSource, IorD, MemToReg},
                           {PCWrite, IRWrite, RegWrite, MemRead, MemWrite})};
                end
                prev = int'(state);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no end of test, expected $finish");
        $fatal(1, "time limit");
    end

    initial begin : main
        rst_n     = 1'b0;
        mon_pause = 1'b1;
        opcode    = 7'd0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        model_ret = 16'd0;

        // While reset is held, the strobes are masked even though mem_ready=1.
        repeat (3) @(negedge clk);
        #1;
        check("reset_state", 32'(state), 32'd0);
        check("reset_retired", 32'(retired), 32'd0);
        check("reset_illegal", 32'(illegal), 32'd0);
        check("reset_strobes", 32'({PCWrite, IRWrite, RegWrite, MemRead, MemWrite}), 32'd0);
        check("reset_alusrcb", 32'(ALUSrcB), 32'd1);

        @(negedge clk);
        rst_n     = 1'b1;
        mon_pause = 1'b0;
        model_ret = 16'd0;
        run_instr(K_RTYPE, 0, 0, 1'b0, 1'b1);
        run_instr(K_LOAD, 0, 2, 1'b0, 1'b1);
        run_instr(K_BRANCH, 0, 0, 1'b1, 1'b1);
        run_instr(K_BRANCH, 0, 0, 1'b0, 1'b1);

        for (int n = 0; n < 300; n++) begin
            int kind;
`ifdef ILLEGAL_TRAP_EN
            kind = $urandom_range(4, 0);
`else
            kind = $urandom_range(5, 0);
`endif
            run_instr(kind, $urandom_range(2, 0), $urandom_range(2, 0), rbit(), 1'b1);
        end

        mem_ready = 1'b0;
        for (int i = 0; i < 20 && sb_trace.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 32'(sb_trace.size()), 32'd0);
        mon_pause = 1'b1;

        // Reset in the middle of a store wait, with five instructions already retired.
        rst_n = 1'b0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        rst_n = 1'b1;
        repeat (5) run_instr(K_RTYPE, 0, 0, 1'b0, 1'b0);
        #1;
        check("retired_before_store", 32'(retired), 32'd5);
        opcode = OP_STORE;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        mem_ready = 1'b0;
        #1;
        check("store_wait_state", 32'(state), 32'd5);
        check("store_wait_memwrite", 32'(MemWrite), 32'd1);
        @(negedge clk);
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("memwrite_forced_low", 32'(MemWrite), 32'd0);
        @(negedge clk);
        #1;
        check("store_reset_state", 32'(state), 32'd0);
        check("store_reset_retired", 32'(retired), 32'd0);
        check("store_reset_memread", 32'(MemRead), 32'd0);

        // Illegal opcode 1111111.
        @(negedge clk);
        rst_n  = 1'b1;
        opcode = 7'b1111111;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        #1;
`ifdef ILLEGAL_TRAP_EN
        check("illegal_state", 32'(state), 32'd10);
        check("illegal_flag", 32'(illegal), 32'd1);
        check("illegal_retired", 32'(retired), 32'd0);
        for (int i = 0; i < 10; i++) begin
            opcode = 7'($urandom);
            step(rbit(), rbit());
            #1;
            check($sformatf("trap_hold_state%0d", i), 32'(state), 32'd10);
            check($sformatf("trap_hold_strobes%0d", i),
                  32'({PCWrite, IRWrite, RegWrite, MemRead, MemWrite}), 32'd0);
            check($sformatf("trap_hold_illegal%0d", i), 32'(illegal), 32'd1);
        end
`else
        check("illegal_nop_state", 32'(state), 32'd0);
        check("illegal_nop_retired", 32'(retired), 32'd1);
        check("illegal_nop_flag", 32'(illegal), 32'd0);
`endif
        rst_n = 1'b0;
        step(1'b0, 1'b0);
        #1;
        check("illegal_reset_state", 32'(state), 32'd0);
        check("illegal_reset_flag", 32'(illegal), 32'd0);

        // Retired counter wrap: preload 0xFFFE while idle in FETCH, then retire two andi.
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        force dut.retired = 16'hFFFE;
        #1;
        release dut.retired;
        #1;
        check("wrap_preload", 32'(retired), 32'h0000FFFE);
        run_instr(K_ITYPE, 0, 0, 1'b0, 1'b0);
        #1;
        check("wrap_ffff", 32'(retired), 32'h0000FFFF);
        run_instr(K_ITYPE, 0, 0, 1'b0, 1'b0);
        #1;
        check("wrap_zero", 32'(retired), 32'h00000000);
        check("wrap_state", 32'(state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/unidade_controle_multiciclo.md
UNIDADE_CONTROLE_MULTICICLO -- requirements
Module: unidade_controle_multiciclo

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset; all state changes on rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk edge.
REQ-004 opcode  input  7  opcode field of the instruction register; valid from DECODE onward.
REQ-005 zero  input  1  ALU zero flag; used only in BRANCH.
REQ-006 mem_ready  input  1  memory completion strobe; a transfer completes on any cycle with MemRead|MemWrite=1 and mem_ready=1.
REQ-007 PCWrite  output  1  PC load enable.
REQ-008 IRWrite  output  1  instruction register load enable.
REQ-009 RegWrite  output  1  register file write enable.
REQ-010 MemRead  output  1  memory read request.
REQ-011 MemWrite  output  1  memory write request.
REQ-012 IorD  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-013 MemToReg  output  1  writeback select: 0=ALUOut, 1=memory data register.
REQ-014 ALUSrcA  output  1  ALU A select: 0=PC, 1=rs1.
REQ-015 ALUSrcB  output  2  ALU B select: 00=rs2, 01=constant 4, 10=imm, 11=branch offset.
REQ-016 ALUOp  output  2  ALU control class: 00=ADD, 01=SUB, 10=decode funct, 11=AND.
REQ-017 PCSource  output  1  PC input select: 0=ALU result, 1=ALUOut.
REQ-018 state  output  4  current FSM state encoding.
REQ-019 retired  output  16  count of completed instructions.
REQ-020 illegal  output  1  sticky illegal-opcode flag.

Function
REQ-021 States/encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, TRAP=10; codes 11-15 go to FETCH next cycle.
REQ-022 Outputs are Moore-decoded from state, except PCWrite/IRWrite (gated by mem_ready or zero); unlisted outputs 0, ALUOp=00.
REQ-023 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01; IRWrite=PCWrite=mem_ready; hold until mem_ready=1, then DECODE.
REQ-024 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next by opcode: 0000011/0100011->MEM_ADDR, 0110011->EXEC_R, 0010011->EXEC_I, 1100011->BRANCH, other->per REQ-036.
REQ-025 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEM_READ for 0000011, MEM_WRITE for 0100011.
REQ-026 MEM_READ: MemRead=1, IorD=1; hold until mem_ready=1, then MEM_WB. MEM_WB: RegWrite=1, MemToReg=1; then FETCH.
REQ-027 MEM_WRITE: MemWrite=1, IorD=1; hold until mem_ready=1, then FETCH.
REQ-028 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10. EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=11. Both -> ALU_WB; ALU_WB: RegWrite=1, MemToReg=0; then FETCH.
REQ-029 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=1, PCWrite=zero; then FETCH.
REQ-030 Zero-wait latency (clk cycles incl. FETCH): R/I=4, load=5, store=4, branch=3; each mem_ready=0 cycle adds one.
REQ-031 MemRead and MemWrite never both 1; mem_ready outside a request state is ignored.
REQ-032 retired increments by 1 on each transition from MEM_WB, MEM_WRITE, ALU_WB or BRANCH to FETCH; wraps 0xFFFF->0x0000.

Reset
REQ-033 rst_n=0 at an edge, in any state including mid-wait: state<=FETCH, retired<=0, illegal<=0; no completion counted.
REQ-034 While rst_n=0, PCWrite, IRWrite, RegWrite, MemRead, MemWrite SHALL be forced 0; after release FETCH outputs apply from first cycle.

Configuration
REQ-035 Macro ILLEGAL_TRAP_EN selects illegal-opcode handling.
REQ-036 Defined: unknown opcode in DECODE -> TRAP; TRAP holds all strobes 0, illegal=1, exits only by reset. Undefined: unknown opcode -> FETCH as NOP, retired increments, illegal tied 0, TRAP unreachable.

Verification
REQ-037 Reset then add (0110011), mem_ready=1 -> states 0,1,6,8,0; RegWrite=1 only in ALU_WB; retired=1.
REQ-038 lh (0000011), mem_ready low 2 cycles in MEM_READ -> 0,1,2,3,3,3,4,0; MemRead/IorD=1 held 3 cycles; 7 cycles total.
REQ-039 beq (1100011), zero=1 then zero=0 -> PCWrite=1 with PCSource=1 in first BRANCH, 0 in second; retired=2.
REQ-040 rst_n=0 during MEM_WRITE wait with retired=0x0005 -> next state FETCH, retired=0, MemWrite=0 while rst_n=0.
REQ-041 opcode 1111111: ILLEGAL_TRAP_EN defined -> state=10, illegal=1, stays 10 cycles; undefined -> FETCH, retired+1, illegal=0.
REQ-042 Preload retired=0xFFFF via 65535 andi (0010011) instructions, one more -> retired=0x0000.
